// File: rtl/kyber_decode_pkg.sv
// Shared constants, FSM state type and helpers for the byte-decode sequencer.
package kyber_decode_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int NUM_COEFFS = 256;
  localparam int MAX_ELL    = 12;
  localparam int BUF_BITS   = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [4:0] bitcnt_t;
  typedef logic [8:0] bytecnt_t;

  function automatic logic ell_valid(input logic [3:0] e, input int maxEll);
    return (e != 4'd0) && (int'(e) <= maxEll);
  endfunction

endpackage

// File: rtl/byte_decode_seq_if.sv
// Byte-in / coefficient-out stream bundle between a producer/consumer and the decoder.
interface byte_decode_seq_if #(
  parameter int MAX_ELL = 12
) ();

  logic               in_valid;
  logic [7:0]         in_byte;
  logic               in_ready;
  logic               out_valid;
  logic [MAX_ELL-1:0] out_coeff;
  logic [7:0]         out_idx;
  logic               out_ready;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_coeff, out_idx
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_coeff, out_idx
  );

endinterface

// File: rtl/decode_bitbuf.sv
// LSB-first bit buffer: pops ell bits off the bottom, appends bytes above the remaining bits.
module decode_bitbuf #(
  parameter int MAX_ELL = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  input  logic [3:0]                    i_ell,
  input  logic                          i_push,
  input  logic [7:0]                    i_byte,
  input  logic                          i_pop,
  output logic [MAX_ELL-1:0]            o_raw,
  output kyber_decode_pkg::bitcnt_t     o_cnt,
  output kyber_decode_pkg::bytecnt_t    o_bytes
);
  import kyber_decode_pkg::*;

  logic [BUF_BITS-1:0] r_buf;
  bitcnt_t             r_cnt;
  bytecnt_t            r_bytes;

  logic [BUF_BITS-1:0] w_shBuf, w_nxtBuf;
  bitcnt_t             w_shCnt, w_nxtCnt;
  logic [MAX_ELL-1:0]  w_mask;

  // A byte arriving alongside a pop lands just above what survives the shift.
  always_comb begin
    w_shBuf  = i_pop ? (r_buf >> i_ell) : r_buf;
    w_shCnt  = i_pop ? (r_cnt - {1'b0, i_ell}) : r_cnt;
    w_nxtBuf = i_push ? (w_shBuf | ({12'd0, i_byte} << w_shCnt)) : w_shBuf;
    w_nxtCnt = i_push ? (w_shCnt + 5'd8) : w_shCnt;
  end

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < MAX_ELL; b++) begin
      w_mask[b] = (b < int'(i_ell));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_bytes <= '0;
    end else if (i_clear) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_bytes <= '0;
    end else begin
      r_buf <= w_nxtBuf;
      r_cnt <= w_nxtCnt;
      if (i_push) r_bytes <= r_bytes + 9'd1;
    end
  end

  assign o_raw   = r_buf[MAX_ELL-1:0] & w_mask;
  assign o_cnt   = r_cnt;
  assign o_bytes = r_bytes;

endmodule

// File: rtl/byte_decode_seq.sv
// Sequencer that unpacks a byte stream into ell-bit coefficients of one polynomial.
// Optional BYTE_DECODE_MODQ_EN reduces 12-bit values >= q by q once.
module byte_decode_seq #(
  parameter int NUM_COEFFS = kyber_decode_pkg::NUM_COEFFS,
  parameter int MAX_ELL    = kyber_decode_pkg::MAX_ELL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ell,
  input  logic             abort,
  byte_decode_seq_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import kyber_decode_pkg::*;

  state_t     r_state;
  logic [3:0] r_ell;
  logic [7:0] r_idx;
  logic       r_busy, r_done, r_err;

  logic [MAX_ELL-1:0] w_raw, w_coeff;
  bitcnt_t            w_cnt;
  bytecnt_t           w_bytes;
  logic [9:0]         w_byteLimit;
  logic               w_run, w_inReady, w_outValid, w_push, w_pop, w_accept, w_clear;

  assign w_run       = (r_state == RUN);
  assign w_byteLimit = 10'(NUM_COEFFS / 8) * {6'd0, r_ell};
  assign w_inReady   = w_run && (w_cnt <= bitcnt_t'(BUF_BITS - 8)) && ({1'b0, w_bytes} < w_byteLimit);
  assign w_outValid  = w_run && (w_cnt >= {1'b0, r_ell});
  assign w_push      = bus.in_valid && w_inReady && !abort;
  assign w_pop       = w_outValid && bus.out_ready && !abort;
  assign w_accept    = (r_state == IDLE) && start && !abort && ell_valid(ell, MAX_ELL);
  assign w_clear     = abort || w_accept;

  decode_bitbuf #(.MAX_ELL(MAX_ELL)) u_bitbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_ell   (r_ell),
    .i_push  (w_push),
    .i_byte  (bus.in_byte),
    .i_pop   (w_pop),
    .o_raw   (w_raw),
    .o_cnt   (w_cnt),
    .o_bytes (w_bytes)
  );

  always_comb begin
    w_coeff = w_raw;
`ifdef BYTE_DECODE_MODQ_EN
    if (r_ell == 4'd12 && w_raw >= MAX_ELL'(KYBER_Q)) w_coeff = w_raw - MAX_ELL'(KYBER_Q);
`endif
  end

  // Abort outranks everything, including a handoff of the last coefficient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ell   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (ell_valid(ell, MAX_ELL)) begin
                r_state <= RUN;
                r_ell   <= ell;
                r_idx   <= '0;
                r_busy  <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          RUN: begin
            if (w_pop) begin
              r_idx <= r_idx + 8'd1;
              if (r_idx == 8'(NUM_COEFFS - 1)) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_coeff = w_coeff;
  assign bus.out_idx   = r_idx;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_byte_decode_seq.sv
// Directed self-checking bench for byte_decode_seq; expectations follow BYTE_DECODE_MODQ_EN.
module tb_byte_decode_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] ell   = 4'd0;
  logic       abort = 1'b0;
  logic       busy, done, err;

  byte_decode_seq_if #(.MAX_ELL(12)) bus ();

  byte_decode_seq #(.NUM_COEFFS(256), .MAX_ELL(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ell   (ell),
    .abort (abort),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

`ifdef BYTE_DECODE_MODQ_EN
  localparam logic [11:0] SAT_EXP = 12'd766;
`else
  localparam logic [11:0] SAT_EXP = 12'd4095;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]  streamBytes [0:383];
  logic [11:0] recCoeff [0:255];
  logic [7:0]  recIdx [0:255];
  int recN, doneCnt, sentCnt, stallNotReady, stallValid, lastHsCyc;
  bit timedOut, stallChanged, readyAfterEnd;

  // Reference: coefficient k is stream bits k*e .. k*e+e-1, LSB-first within each byte.
  function automatic logic [11:0] modelCoeff(input int k, input int e);
    logic [11:0] v;
    v = '0;
    for (int j = 0; j < e; j++) begin
      int p;
      p = k * e + j;
      v[j] = streamBytes[p / 8][p % 8];
    end
`ifdef BYTE_DECODE_MODQ_EN
    if (e == 12 && v >= 12'd3329) v = v - 12'd3329;
`endif
    return v;
  endfunction

  task automatic doStart(input logic [3:0] e);
    start = 1'b1;
    ell   = e;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic doAbort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  // Drives bytes and out_ready cycle by cycle, recording every handoff seen between edges.
  task automatic driveStream(input int nBytes, input int wantN, input int stallAt,
                             input int stallLen, input int stopIdx, input int maxCycles);
    int tail;
    bit latched, inStall;
    logic [11:0] hCoeff;
    logic [7:0]  hIdx;
    tail = 0; latched = 0; hCoeff = '0; hIdx = '0;
    recN = 0; doneCnt = 0; sentCnt = 0; stallNotReady = 0; stallValid = 0; lastHsCyc = -1;
    timedOut = 1; stallChanged = 0; readyAfterEnd = 0;
    for (int cyc = 0; cyc < maxCycles; cyc++) begin
      inStall       = (cyc >= stallAt) && (cyc < stallAt + stallLen);
      bus.in_valid  = (sentCnt < nBytes);
      bus.in_byte   = (sentCnt < nBytes) ? streamBytes[sentCnt] : 8'h00;
      bus.out_ready = !inStall;
      if (stopIdx >= 0 && bus.out_valid && int'(bus.out_idx) == stopIdx) begin
        timedOut = 0;
        break;
      end
      if (done) doneCnt++;
      if (sentCnt >= nBytes && bus.in_ready) readyAfterEnd = 1;
      if (inStall) begin
        if (!bus.in_ready) stallNotReady++;
        if (bus.out_valid) begin
          stallValid++;
          if (!latched) begin
            latched = 1;
            hCoeff  = bus.out_coeff;
            hIdx    = bus.out_idx;
          end else if (bus.out_coeff !== hCoeff || bus.out_idx !== hIdx) begin
            stallChanged = 1;
          end
        end
      end
      if (bus.out_valid && bus.out_ready && recN < 256) begin
        recCoeff[recN] = bus.out_coeff;
        recIdx[recN]   = bus.out_idx;
        recN++;
        lastHsCyc = cyc;
      end
      if (bus.in_valid && bus.in_ready) sentCnt++;
      if (recN >= wantN && sentCnt >= nBytes) begin
        tail++;
        if (tail > 3) begin
          timedOut = 0;
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL reset_done_err: got %b/%b expected 0/0", done, err); end
    total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_hs: got %b/%b expected 0/0", bus.in_ready, bus.out_valid); end
    total++; if (bus.out_coeff !== 12'd0 || bus.out_idx !== 8'd0) begin bad++; $display("[TB] FAIL reset_data: got %0d/%0d expected 0/0", bus.out_coeff, bus.out_idx); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_ell12_basic();
    streamBytes[0] = 8'h49; streamBytes[1] = 8'h8B; streamBytes[2] = 8'h0B;
    doStart(4'd12);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
    driveStream(3, 2, 1000, 0, -1, 50);
    total++; if (timedOut !== 1'b0 || recN != 2) begin bad++; $display("[TB] FAIL basic_count: got %0d handoffs expected 2", recN); end
    total++; if (recCoeff[0] !== 12'd2889 || recIdx[0] !== 8'd0) begin bad++; $display("[TB] FAIL basic_c0: got %0d@%0d expected 2889@0", recCoeff[0], recIdx[0]); end
    total++; if (recCoeff[1] !== 12'd184 || recIdx[1] !== 8'd1) begin bad++; $display("[TB] FAIL basic_c1: got %0d@%0d expected 184@1", recCoeff[1], recIdx[1]); end
    doAbort();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL basic_abort: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_ell1();
    logic [11:0] expBits [0:7];
    expBits = '{12'd1, 12'd0, 12'd1, 12'd0, 12'd0, 12'd1, 12'd0, 12'd1};
    streamBytes[0] = 8'hA5;
    doStart(4'd1);
    driveStream(1, 8, 1000, 0, -1, 50);
    total++; if (timedOut !== 1'b0 || recN != 8) begin bad++; $display("[TB] FAIL ell1_count: got %0d expected 8", recN); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (recCoeff[k] !== expBits[k] || recIdx[k] !== 8'(k)) begin
        bad++; $display("[TB] FAIL ell1_c%0d: got %0d@%0d expected %0d@%0d", k, recCoeff[k], recIdx[k], expBits[k], k);
      end
    end
    doAbort();
  endtask

  task automatic test_modq();
    streamBytes[0] = 8'hFF; streamBytes[1] = 8'hFF; streamBytes[2] = 8'hFF;
    doStart(4'd12);
    driveStream(3, 2, 1000, 0, -1, 50);
    total++; if (timedOut !== 1'b0 || recN != 2) begin bad++; $display("[TB] FAIL modq_count: got %0d expected 2", recN); end
    total++; if (recCoeff[0] !== SAT_EXP || recCoeff[1] !== SAT_EXP) begin bad++; $display("[TB] FAIL modq_val: got %0d,%0d expected %0d", recCoeff[0], recCoeff[1], SAT_EXP); end
    doAbort();
  endtask

  task automatic test_full_throughput();
    int cErr, iErr;
    for (int i = 0; i < 384; i++) streamBytes[i] = 8'($urandom_range(0, 255));
    doStart(4'd12);
    driveStream(384, 256, 100000, 0, -1, 2000);
    cErr = 0; iErr = 0;
    for (int k = 0; k < 256; k++) begin
      if (recCoeff[k] !== modelCoeff(k, 12)) cErr++;
      if (recIdx[k] !== 8'(k)) iErr++;
    end
    total++; if (timedOut !== 1'b0 || recN != 256) begin bad++; $display("[TB] FAIL full_count: got %0d handoffs expected 256", recN); end
    total++; if (cErr != 0) begin bad++; $display("[TB] FAIL full_coeffs: got %0d wrong expected 0", cErr); end
    total++; if (iErr != 0) begin bad++; $display("[TB] FAIL full_idx: got %0d wrong expected 0", iErr); end
    total++; if (doneCnt != 1) begin bad++; $display("[TB] FAIL full_done: got %0d pulses expected 1", doneCnt); end
    total++; if (readyAfterEnd !== 1'b0 || sentCnt != 384) begin bad++; $display("[TB] FAIL full_inready: got ready=%b sent=%0d expected 0/384", readyAfterEnd, sentCnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL full_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_ell8_rate();
    int cErr;
    for (int i = 0; i < 16; i++) streamBytes[i] = 8'($urandom_range(0, 255));
    doStart(4'd8);
    driveStream(16, 16, 100000, 0, -1, 100);
    cErr = 0;
    for (int k = 0; k < 16; k++) if (recCoeff[k] !== {4'd0, streamBytes[k]}) cErr++;
    total++; if (timedOut !== 1'b0 || recN != 16 || cErr != 0) begin bad++; $display("[TB] FAIL rate_data: got n=%0d wrong=%0d expected 16/0", recN, cErr); end
    total++; if (lastHsCyc != 16) begin bad++; $display("[TB] FAIL rate_cycles: got last handoff at %0d expected 16", lastHsCyc); end
    doAbort();
  endtask

  task automatic test_backpressure();
    int cErr, iErr;
    for (int i = 0; i < 48; i++) streamBytes[i] = 8'($urandom_range(0, 255));
    doStart(4'd12);
    driveStream(48, 32, 7, 5, -1, 300);
    cErr = 0; iErr = 0;
    for (int k = 0; k < 32; k++) begin
      if (recCoeff[k] !== modelCoeff(k, 12)) cErr++;
      if (recIdx[k] !== 8'(k)) iErr++;
    end
    total++; if (timedOut !== 1'b0 || recN != 32 || sentCnt != 48) begin bad++; $display("[TB] FAIL bp_count: got n=%0d sent=%0d expected 32/48", recN, sentCnt); end
    total++; if (cErr != 0 || iErr != 0) begin bad++; $display("[TB] FAIL bp_data: got %0d/%0d wrong expected 0/0", cErr, iErr); end
    total++; if (stallChanged !== 1'b0 || stallValid != 4) begin bad++; $display("[TB] FAIL bp_stable: got changed=%b valid=%0d expected 0/4", stallChanged, stallValid); end
    total++; if (stallNotReady != 3) begin bad++; $display("[TB] FAIL bp_inready: got %0d not-ready cycles expected 3", stallNotReady); end
    doAbort();
  endtask

  task automatic test_abort();
    doStart(4'd4);
    bus.in_valid = 1'b1; bus.in_byte = 8'h3C;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_coeff !== 12'd12) begin bad++; $display("[TB] FAIL abort_pre: got %b/%0d expected 1/12", bus.out_valid, bus.out_coeff); end
    abort = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    total++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_coeff !== 12'd0) begin bad++; $display("[TB] FAIL abort_idle: got %b/%b/%0d expected 0/0/0", busy, bus.out_valid, bus.out_coeff); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    streamBytes[0] = 8'h3C;
    doStart(4'd4);
    driveStream(1, 2, 1000, 0, -1, 50);
    total++; if (recN != 2 || recCoeff[0] !== 12'd12 || recIdx[0] !== 8'd0 || recCoeff[1] !== 12'd3) begin bad++; $display("[TB] FAIL abort_restart: got n=%0d %0d@%0d,%0d expected 2 12@0,3", recN, recCoeff[0], recIdx[0], recCoeff[1]); end
    doAbort();
  endtask

  task automatic test_bad_ell();
    start = 1'b1; ell = 4'd13;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL bad13_pulse: got err=%b busy=%b expected 1/0", err, busy); end
    @(posedge clk); #1;
    total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL bad13_after: got err=%b busy=%b expected 0/0", err, busy); end
    start = 1'b1; ell = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL bad0_pulse: got err=%b busy=%b expected 1/0", err, busy); end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 384; i++) streamBytes[i] = 8'($urandom_range(0, 255));
    doStart(4'd12);
    driveStream(384, 256, 100000, 0, 100, 2000);
    total++; if (timedOut !== 1'b0) begin bad++; $display("[TB] FAIL midrst_reach: got timeout expected idx 100"); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_idx !== 8'd0 || bus.out_coeff !== 12'd0) begin bad++; $display("[TB] FAIL midrst_data: got %0d/%0d expected 0/0", bus.out_idx, bus.out_coeff); end
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("[TB] FAIL midrst_flags: got %b%b%b%b%b expected 00000", bus.out_valid, bus.in_ready, busy, done, err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_idle: got busy=%b expected 0", busy); end
    streamBytes[0] = 8'h49; streamBytes[1] = 8'h8B; streamBytes[2] = 8'h0B;
    doStart(4'd12);
    driveStream(3, 2, 1000, 0, -1, 50);
    total++; if (recN != 2 || recCoeff[0] !== 12'd2889 || recIdx[0] !== 8'd0 || recIdx[1] !== 8'd1) begin bad++; $display("[TB] FAIL midrst_restart: got n=%0d %0d@%0d expected 2 2889@0", recN, recCoeff[0], recIdx[0]); end
    doAbort();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_ell12_basic();
    test_ell1();
    test_modq();
    test_full_throughput();
    test_ell8_rate();
    test_backpressure();
    test_abort();
    test_bad_ell();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
